// File: rtl/audio_stream_pkg.sv
// Shared constants and helpers for the audio output streaming path.
package audio_stream_pkg;

  localparam int unsigned SAMPLE_W   = 32;
  localparam int unsigned GAIN_UNITY = 16;
  localparam int unsigned CNT_W      = 8;

  function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned sample_hz);
    return clk_hz / sample_hz;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/audio_sample_fifo.sv
// Show-ahead synchronous sample FIFO; a push into a full FIFO is accepted only alongside a pop.
module audio_sample_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             push_data,
  output logic [W-1:0]             head,
  output logic                     empty,
  output logic                     full,
  output logic                     push_ok,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign push_ok = do_push;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/audio_out_streamer.sv
// Decimates the synth stream to the sample rate, applies a ramped gain and feeds
// Audio_Controller from a small FIFO, counting underruns and dropped samples.
module audio_out_streamer
  import audio_stream_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned SAMPLE_HZ  = 48_000,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned GAIN_W     = 5
) (
  input  logic                          CLOCK_50,
  input  logic                          reset,
  input  logic [SAMPLE_W-1:0]           channel_audio_out,
  input  logic [GAIN_W-1:0]             volume,
  input  logic                          mute,
  input  logic                          audio_out_allowed,
  output logic [SAMPLE_W-1:0]           left_channel_audio_out,
  output logic [SAMPLE_W-1:0]           right_channel_audio_out,
  output logic                          write_audio_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]              underrun_count,
  output logic [CNT_W-1:0]              overflow_count
);

  localparam int unsigned DIV    = calc_div(CLK_HZ, SAMPLE_HZ);
  localparam int unsigned TICK_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned PROD_W = SAMPLE_W + GAIN_W;

  logic [TICK_W-1:0]          tick_cnt;
  logic                       tick;
  logic [GAIN_W-1:0]          cur_gain;
  logic [GAIN_W-1:0]          target;

  logic signed [SAMPLE_W-1:0] cap;
  logic [GAIN_W-1:0]          cap_gain;
  logic                       cap_vld;
  logic signed [PROD_W-1:0]   cap_ext;
  logic signed [PROD_W-1:0]   gain_ext;
  logic signed [PROD_W-1:0]   prod;
  logic                       prod_vld;
  logic [SAMPLE_W-1:0]        scaled;

  logic [SAMPLE_W-1:0]        head;
  logic [SAMPLE_W-1:0]        last_q;
  logic                       fifo_empty;
  logic                       fifo_full;
  logic                       push_ok;
  logic                       pop;

  assign tick = (tick_cnt == TICK_W'(DIV - 1));

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) tick_cnt <= '0;
    else       tick_cnt <= tick ? '0 : tick_cnt + TICK_W'(1);
  end

  always_comb begin
    target = '0;
    if (!mute) target = (volume > GAIN_W'(GAIN_UNITY)) ? GAIN_W'(GAIN_UNITY) : volume;
  end

  // The captured gain is the pre-step value, so the sample taken on a tick
  // is scaled by the gain in force during that tick.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      cur_gain <= '0;
      cap      <= '0;
      cap_gain <= '0;
      cap_vld  <= 1'b0;
      prod     <= '0;
      prod_vld <= 1'b0;
    end else begin
      cap_vld  <= tick;
      prod_vld <= cap_vld;
      if (tick) begin
        cap      <= channel_audio_out;
        cap_gain <= cur_gain;
        if (cur_gain < target)      cur_gain <= cur_gain + GAIN_W'(1);
        else if (cur_gain > target) cur_gain <= cur_gain - GAIN_W'(1);
      end
      if (cap_vld) prod <= cap_ext * gain_ext;
    end
  end

  assign cap_ext  = PROD_W'(cap);
  assign gain_ext = {{SAMPLE_W{1'b0}}, cap_gain};
  assign scaled   = SAMPLE_W'(prod >>> 4);

  assign pop = audio_out_allowed && !fifo_empty;

  audio_sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (SAMPLE_W)
  ) u_fifo (
    .clk       (CLOCK_50),
    .rst       (reset),
    .push      (prod_vld),
    .pop       (pop),
    .push_data (scaled),
    .head      (head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .push_ok   (push_ok),
    .level     (fifo_level)
  );

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      underrun_count <= '0;
      overflow_count <= '0;
      last_q         <= '0;
    end else begin
      if (tick && audio_out_allowed && fifo_empty) underrun_count <= sat_inc(underrun_count);
      if (prod_vld && !push_ok)                     overflow_count <= sat_inc(overflow_count);
      if (!fifo_empty)                              last_q <= head;
    end
  end

  assign write_audio_out         = pop;
  assign left_channel_audio_out  = fifo_empty ? last_q : head;
  assign right_channel_audio_out = left_channel_audio_out;

endmodule

// File: tb/tb_audio_out_streamer.sv
// Bench for audio_out_streamer: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
`timescale 1ns/1ps
module tb_audio_out_streamer;

  localparam int DIV   = 20;
  localparam int DEPTH = 8;

  logic        CLOCK_50 = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] channel_audio_out = '0;
  logic [4:0]  volume = '0;
  logic        mute = 1'b0;
  logic        audio_out_allowed = 1'b0;
  logic [31:0] left_channel_audio_out;
  logic [31:0] right_channel_audio_out;
  logic        write_audio_out;
  logic [3:0]  fifo_level;
  logic [7:0]  underrun_count;
  logic [7:0]  overflow_count;

  int n_checks = 0;
  int n_errors = 0;

  audio_out_streamer #(
    .CLK_HZ     (960_000),
    .SAMPLE_HZ  (48_000),
    .FIFO_DEPTH (8),
    .GAIN_W     (5)
  ) dut (
    .CLOCK_50                (CLOCK_50),
    .reset                   (reset),
    .channel_audio_out       (channel_audio_out),
    .volume                  (volume),
    .mute                    (mute),
    .audio_out_allowed       (audio_out_allowed),
    .left_channel_audio_out  (left_channel_audio_out),
    .right_channel_audio_out (right_channel_audio_out),
    .write_audio_out         (write_audio_out),
    .fifo_level              (fifo_level),
    .underrun_count          (underrun_count),
    .overflow_count          (overflow_count)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: a sample produced on a tick enters the FIFO queue two cycles later.
  typedef struct {
    int          push_cyc;
    logic [31:0] val;
  } pend_t;

  pend_t       pend_q[$];
  logic [31:0] fifo_q[$];
  pend_t       pe;
  int          m_cyc = 0;
  int          m_gain = 0;
  int          tgt;
  int          sz;
  bit          tk;
  bit          pp;
  bit          fl;
  longint      prd;
  logic [7:0]  m_under = '0;
  logic [7:0]  m_over = '0;
  logic [31:0] m_last = '0;

  function automatic logic [7:0] sat8(input logic [7:0] v);
    return (v == 8'd255) ? v : v + 8'd1;
  endfunction

  initial forever begin
    @(posedge CLOCK_50 or posedge reset);
    if (reset) begin
      pend_q.delete();
      fifo_q.delete();
      m_cyc = 0; m_gain = 0; m_under = '0; m_over = '0; m_last = '0;
    end else begin
      tk = (m_cyc % DIV) == DIV - 1;
      sz = fifo_q.size();
      pp = audio_out_allowed && sz > 0;
      fl = (sz == DEPTH);
      if (tk && audio_out_allowed && sz == 0) m_under = sat8(m_under);
      if (pp) begin
        m_last = fifo_q[0];
        void'(fifo_q.pop_front());
      end
      if (pend_q.size() > 0 && pend_q[0].push_cyc == m_cyc) begin
        if (!fl || pp) fifo_q.push_back(pend_q[0].val);
        else           m_over = sat8(m_over);
        void'(pend_q.pop_front());
      end
      if (tk) begin
        prd = longint'($signed(channel_audio_out)) * longint'(m_gain);
        pe.push_cyc = m_cyc + 2;
        pe.val = 32'(prd >>> 4);
        pend_q.push_back(pe);
        tgt = mute ? 0 : ((volume > 5'd16) ? 16 : int'(volume));
        if (m_gain < tgt)      m_gain++;
        else if (m_gain > tgt) m_gain--;
      end
      m_cyc++;
    end
  end

  logic        e_w;
  logic [31:0] e_d;

  initial forever begin
    @(negedge CLOCK_50);
    if (fifo_q.size() > 0) begin e_w = audio_out_allowed; e_d = fifo_q[0]; end
    else                   begin e_w = 1'b0;              e_d = m_last;    end
    check("write_audio_out", {31'd0, write_audio_out}, {31'd0, e_w});
    check("left", left_channel_audio_out, e_d);
    check("right", right_channel_audio_out, e_d);
    check("fifo_level", 32'(fifo_level), 32'(fifo_q.size()));
    check("underrun_count", 32'(underrun_count), 32'(m_under));
    check("overflow_count", 32'(overflow_count), 32'(m_over));
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLOCK_50);
      #2;
    end
  endtask

  task automatic wait_write(input string name, output logic [31:0] v);
    bit got;
    got = 0;
    v = '0;
    for (int i = 0; i < 3 * DIV && !got; i++) begin
      @(negedge CLOCK_50);
      if (write_audio_out) begin
        got = 1;
        v = left_channel_audio_out;
      end
    end
    @(posedge CLOCK_50);
    #2;
    check({name, "_timeout"}, {31'd0, got}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  logic [31:0] v;
  logic [31:0] prev;
  int          wcnt;
  int          mode;

  initial begin
    step(3);
    check("reset_left", left_channel_audio_out, 32'd0);
    check("reset_write", {31'd0, write_audio_out}, 32'd0);
    check("reset_level", 32'(fifo_level), 32'd0);
    check("reset_underrun", 32'(underrun_count), 32'd0);

    // Ramp up from gain 0 at unity target.
    volume = 5'd16; mute = 1'b0; channel_audio_out = 32'h0100_0000; audio_out_allowed = 1'b1;
    reset = 1'b0;
    wait_write("first_write", v);
    check("first_write_zero", v, 32'd0);
    step(20 * DIV);
    wait_write("unity_write", v);
    check("unity_value", v, 32'h0100_0000);

    // Half gain on a negative sample.
    volume = 5'd8; channel_audio_out = 32'hFFFF_F9C0;
    step(12 * DIV);
    wait_write("half_write", v);
    check("half_value", v, 32'hFFFF_FCE0);

    // Controller stalled for ten ticks.
    audio_out_allowed = 1'b0;
    wcnt = 0;
    for (int i = 0; i < 10 * DIV; i++) begin
      channel_audio_out = $urandom;
      @(negedge CLOCK_50);
      if (write_audio_out) wcnt++;
      @(posedge CLOCK_50);
      #2;
    end
    check("stall_no_writes", 32'(wcnt), 32'd0);
    check("stall_level", 32'(fifo_level), 32'd8);
    check("stall_overflow", 32'(overflow_count), 32'd2);
    audio_out_allowed = 1'b1;
    wcnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLOCK_50);
      if (write_audio_out) wcnt++;
      @(posedge CLOCK_50);
      #2;
    end
    check("drain_burst", 32'(wcnt), 32'd8);
    check("drain_level", 32'(fifo_level), 32'd0);

    // Mute ramp down then back up.
    volume = 5'd16; channel_audio_out = 32'h0100_0000;
    step(12 * DIV);
    mute = 1'b1;
    prev = 32'h7FFF_FFFF;
    for (int i = 0; i < 20; i++) begin
      wait_write("mute_write", v);
      check("mute_nonincreasing", {31'd0, (v <= prev)}, 32'd1);
      prev = v;
    end
    check("mute_final", v, 32'd0);
    mute = 1'b0;
    step(20 * DIV);
    wait_write("unmute_write", v);
    check("unmute_value", v, 32'h0100_0000);

    // Every tick with an empty FIFO is an underrun; counter saturates.
    step(300 * DIV);
    check("underrun_saturated", 32'(underrun_count), 32'd255);

    // Reset with five samples queued and one in the pipeline.
    wait_write("pre_reset_write", v);
    audio_out_allowed = 1'b0;
    step(6 * DIV - 3);
    check("pre_reset_level", 32'(fifo_level), 32'd5);
    #1 reset = 1'b1;
    audio_out_allowed = 1'b1;
    #1;
    check("async_reset_left", left_channel_audio_out, 32'd0);
    check("async_reset_level", 32'(fifo_level), 32'd0);
    check("async_reset_underrun", 32'(underrun_count), 32'd0);
    check("async_reset_write", {31'd0, write_audio_out}, 32'd0);
    step(2);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLOCK_50);
      check("post_reset_no_write", {31'd0, write_audio_out}, 32'd0);
    end
    @(posedge CLOCK_50);
    #2;

    // Randomized traffic against the model.
    mode = 0;
    for (int i = 0; i < 4000; i++) begin
      channel_audio_out = $urandom;
      if (i % 97 == 0) begin
        volume = 5'($urandom_range(0, 31));
        mute = ($urandom_range(0, 3) == 0);
      end
      if (i % 150 == 0) mode = $urandom_range(0, 2);
      case (mode)
        0:       audio_out_allowed = 1'b1;
        1:       audio_out_allowed = ($urandom_range(0, 7) == 0);
        default: audio_out_allowed = 1'($urandom_range(0, 1));
      endcase
      step(1);
    end
    step(5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
